rx_seq_buffer: RTL and testbench
================================

# rx_seq_buffer

Receive-side buffer sitting directly downstream of the handshake receiver in the same clock domain. It watches the receiver's `ack` level and `data` bus, and captures one word per ack rising edge into a small first-word-fall-through FIFO. It presents buffered words on a valid/ready stream and checks that captured words form the incrementing sequence produced by the sender counter.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 4, FIFO depth in words; power of two, ≥ 2.
- `clk` input 1 — single clock; all state updates on posedge.
- `rst` input 1 — synchronous, active-low reset (sampled on posedge `clk`).
- `in_ack` input 1 — receiver ack level; rising edge marks a new word.
- `in_data` input WIDTH — receiver data bus, valid while `in_ack` is high.
- `out_data` output WIDTH — head-of-FIFO word, meaningful when `out_valid`=1.
- `out_valid` output 1 — FIFO not empty.
- `out_ready` input 1 — consumer accepts the head word this cycle.
- `count` output $clog2(DEPTH)+1 — words currently stored.
- `full` output 1 — `count`==DEPTH.
- `overflow` output 1 — sticky; a word was dropped because the FIFO was full.
- `seq_err` output 1 — sticky; a captured word broke the expected sequence.
- `words` output 16 — total capture events since reset, wraps mod 2^16.

## Operation
- Edge detect: `ack_d` <= `in_ack` every cycle. Capture event `cap` = `in_ack` & ~`ack_d`. `ack_d` resets to 1, so an `in_ack` already high at reset release is not captured. The next capture needs `in_ack` low for at least one cycle first.
- On `cap`:
  - `words` increments.
  - If ~`full`, `in_data` is written at `wr_ptr`, `wr_ptr` advances mod DEPTH, and `count` increments.
  - If `full`, the word is dropped and `overflow` <= 1.
- Pop: `pop` = `out_valid` & `out_ready`. `rd_ptr` advances mod DEPTH and `count` decrements.
- Same-cycle `cap` and `pop`:
  - FIFO not full: both take effect and `count` is unchanged.
  - FIFO full: the pop proceeds and the push is dropped, because `full` is evaluated from the pre-edge state and `overflow` sets.
- `out_data` = `mem[rd_ptr]`, a combinational read of registered storage. `out_valid` = (`count`≠0). Both are stable until a pop.
- Sequence checker:
  - `expected` register resets to 0.
  - On every `cap`, including dropped words, compare `in_data` with `expected`.
  - Match: `expected` <= `expected`+1, mod 2^WIDTH, so 0xFF→0x00 for WIDTH=8.
  - Mismatch: `seq_err` <= 1 and `expected` <= `in_data`+1, which resyncs the checker.
- Sticky flags clear only on reset.

## Timing
- Reset (`rst`=0 at a posedge) gives:
  - `count`=0, `out_valid`=0, `full`=0, `overflow`=0, `seq_err`=0, `words`=0.
  - Pointers=0, `expected`=0, `ack_d`=1.
  - `out_data` reads `mem[0]`, which is don't-care while `out_valid`=0; memory contents are not reset.
- Reset mid-operation discards all buffered words on that edge; nothing is popped or pushed on the reset edge.
- Capture latency: `in_ack` sampled 1 with `ack_d`=0 at edge k → word stored, `out_valid`=1 and `count` updated after edge k. The word is poppable at edge k+1 at the earliest.
- `in_data` is sampled on the same edge as the `in_ack` rising edge. An `in_ack` held high for N cycles produces exactly one capture.
- Minimum capture spacing is 2 cycles (high, low, high). Every qualifying rising edge is captured.
- Pop: `out_ready`=1 and `out_valid`=1 at edge k → next word, or `out_valid`=0, after edge k.
- `overflow` and `seq_err` assert on the edge of the offending capture and are visible the following cycle.

## Test plan
- Reset hold: `rst`=0 for 3 cycles while `in_ack` toggles → all outputs 0, `words`=0. After release with `in_ack` already high, no capture until `in_ack` falls and rises again.
- Sequence fill/drain: capture 0x00,0x01,0x02,0x03 with `out_ready`=0 → `count`=4, `full`=1, `seq_err`=0. Then `out_ready`=1 → pops 0x00..0x03 in order, one per cycle, `out_valid`=0 after the 4th.
- Overflow: with the FIFO full of 0x00..0x03, capture 0x04 → dropped, `overflow`=1, `count`=4, `words`=5, `seq_err`=0. Next capture 0x05 is then accepted after one pop.
- Simultaneous push/pop: `count`=2, `cap` of the next word with `out_ready`=1 in the same cycle → `count` stays 2 and the order is preserved. Repeat at `count`=4 → pop occurs, push dropped, `overflow`=1.
- Sequence error and wrap:
  - Captures 0xFE,0xFF,0x00 after `expected` is primed → no `seq_err`.
  - Then capture 0x05 instead of 0x01 → `seq_err`=1.
  - Next capture 0x06 matches the resynced `expected`, and `seq_err` stays 1.
- Long ack: `in_ack` held high 10 cycles with changing `in_data` → exactly one capture, with the value present on the rising-edge cycle.

Source files
------------

// File: rtl/rx_seq_buffer_if.sv
// Receiver-side capture inputs and the buffered output stream with status flags.
interface rx_seq_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                     in_ack;
  logic [WIDTH-1:0]         in_data;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     overflow;
  logic                     seq_err;
  logic [15:0]              words;

  modport master (
    output in_ack, in_data, out_ready,
    input  out_data, out_valid, count, full, overflow, seq_err, words
  );

  modport slave (
    input  in_ack, in_data, out_ready,
    output out_data, out_valid, count, full, overflow, seq_err, words
  );
endinterface

// File: rtl/rx_seq_buffer.sv
// Captures one word per in_ack rising edge into a FWFT FIFO and checks the incrementing sequence.
// Word is poppable one cycle after its capture edge; a full FIFO drops new words (overflow), out_ready stalls the head.
module rx_seq_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  rx_seq_buffer_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic             ack_d_q, ack_d_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             seq_err_q, seq_err_d;
  logic [15:0]      words_q, words_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic cap;
  logic pop;
  logic push;
  logic full_w;
  logic valid_w;

  // Full/valid come from pre-edge state, so a push into a full FIFO is dropped even when a pop frees a slot.
  assign full_w  = (count_q == DEPTH_C);
  assign valid_w = (count_q != '0);
  assign cap     = bus.in_ack & ~ack_d_q;
  assign pop     = valid_w & bus.out_ready;
  assign push    = cap & ~full_w;

  always_comb begin
    ack_d_d    = bus.in_ack;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    seq_err_d  = seq_err_q;
    words_d    = words_q;
    expected_d = expected_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Dropped words still count and still advance or resync the sequence checker.
    if (cap) begin
      words_d = words_q + 16'd1;
      if (full_w) begin
        overflow_d = 1'b1;
      end
      if (bus.in_data == expected_q) begin
        expected_d = expected_q + WIDTH'(1);
      end else begin
        seq_err_d  = 1'b1;
        expected_d = bus.in_data + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_d_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
      words_q    <= '0;
      expected_q <= '0;
    end else begin
      ack_d_q    <= ack_d_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
      words_q    <= words_d;
      expected_q <= expected_d;
    end
  end

  // Storage is not reset; count gates whether any entry is meaningful.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = valid_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.overflow  = overflow_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.words     = words_q;
endmodule

// File: tb/tb_rx_seq_buffer.sv
// Directed bench for rx_seq_buffer: queue-based reference model checked every cycle plus literal spot checks.
module tb_rx_seq_buffer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rx_seq_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rx_seq_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus counters, updated from the inputs seen at each edge.
  logic [WIDTH-1:0] mq[$];
  logic             m_prev_ack = 1'b1;
  logic [15:0]      m_words    = '0;
  logic             m_ovf      = 1'b0;
  logic             m_serr     = 1'b0;
  logic [WIDTH-1:0] m_exp      = '0;
  bit               check_en   = 1'b0;
  bit               m_cap, m_pop, m_full;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_prev_ack = 1'b1;
      m_words    = '0;
      m_ovf      = 1'b0;
      m_serr     = 1'b0;
      m_exp      = '0;
      check_en   = 1'b1;
    end else begin
      m_cap  = bus.in_ack && !m_prev_ack;
      m_pop  = (mq.size() != 0) && bus.out_ready;
      m_full = (mq.size() == DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_cap) begin
        m_words = m_words + 16'd1;
        if (m_full) m_ovf = 1'b1;
        else mq.push_back(bus.in_data);
        if (bus.in_data == m_exp) begin
          m_exp = m_exp + 8'd1;
        end else begin
          m_serr = 1'b1;
          m_exp  = bus.in_data + 8'd1;
        end
      end
      m_prev_ack = bus.in_ack;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      chk("count",     {29'd0, bus.count},     mq.size());
      chk("full",      {31'd0, bus.full},      {31'd0, mq.size() == DEPTH});
      chk("overflow",  {31'd0, bus.overflow},  {31'd0, m_ovf});
      chk("seq_err",   {31'd0, bus.seq_err},   {31'd0, m_serr});
      chk("words",     {16'd0, bus.words},     {16'd0, m_words});
      if (mq.size() != 0)
        chk("out_data", {24'd0, bus.out_data}, {24'd0, mq[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [WIDTH-1:0] d);
    bus.in_data = d;
    bus.in_ack  = 1'b1;
    tick();
    bus.in_ack  = 1'b0;
    tick();
  endtask

  task automatic drain_expect(input logic [WIDTH-1:0] v);
    chk("drain_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("drain_data",  {24'd0, bus.out_data},  {24'd0, v});
    tick();
  endtask

  initial begin
    bus.in_ack    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;

    // Reset hold with in_ack toggling, then release with in_ack already high.
    for (int i = 0; i < 3; i++) begin
      bus.in_ack = ~bus.in_ack;
      tick();
    end
    chk("rst_count", {29'd0, bus.count}, 32'd0);
    chk("rst_words", {16'd0, bus.words}, 32'd0);
    bus.in_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rel_words", {16'd0, bus.words},     32'd0);
    chk("rel_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.in_ack = 1'b0;
    tick();

    // Fill to full, overflow, one pop, accept the next word, then drain in order.
    for (int i = 0; i < 4; i++) capture(8'(i));
    chk("fill_count", {29'd0, bus.count},   32'd4);
    chk("fill_full",  {31'd0, bus.full},    32'd1);
    chk("fill_serr",  {31'd0, bus.seq_err}, 32'd0);
    capture(8'h04);
    chk("ovf_flag",  {31'd0, bus.overflow}, 32'd1);
    chk("ovf_count", {29'd0, bus.count},    32'd4);
    chk("ovf_words", {16'd0, bus.words},    32'd5);
    chk("ovf_serr",  {31'd0, bus.seq_err},  32'd0);
    chk("ovf_head",  {24'd0, bus.out_data}, 32'h00);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    capture(8'h05);
    chk("acc_count", {29'd0, bus.count}, 32'd4);
    bus.out_ready = 1'b1;
    drain_expect(8'h01);
    drain_expect(8'h02);
    drain_expect(8'h03);
    drain_expect(8'h05);
    chk("empty_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;

    // Simultaneous push and pop at count 2, then at full.
    capture(8'h06);
    capture(8'h07);
    bus.in_data   = 8'h08;
    bus.in_ack    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("pp2_count", {29'd0, bus.count},    32'd2);
    chk("pp2_head",  {24'd0, bus.out_data}, 32'h07);
    bus.in_ack    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    capture(8'h09);
    capture(8'h0A);
    chk("pp4_pre", {29'd0, bus.count}, 32'd4);
    bus.in_data   = 8'h0B;
    bus.in_ack    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("pp4_count", {29'd0, bus.count},    32'd3);
    chk("pp4_head",  {24'd0, bus.out_data}, 32'h08);
    bus.in_ack = 1'b0;
    drain_expect(8'h08);
    drain_expect(8'h09);
    drain_expect(8'h0A);
    chk("pp_serr", {31'd0, bus.seq_err}, 32'd0);
    bus.out_ready = 1'b0;

    // Reset mid-operation discards buffered words and clears sticky flags.
    capture(8'h0C);
    capture(8'h0D);
    rst = 1'b0;
    tick();
    chk("mid_count", {29'd0, bus.count},    32'd0);
    chk("mid_ovf",   {31'd0, bus.overflow}, 32'd0);
    chk("mid_words", {16'd0, bus.words},    32'd0);
    rst = 1'b1;
    tick();

    // Prime expected up to 0xFE, then wrap, then break and resync.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 254; i++) capture(8'(i));
    capture(8'hFE);
    capture(8'hFF);
    capture(8'h00);
    chk("wrap_serr", {31'd0, bus.seq_err}, 32'd0);
    capture(8'h05);
    chk("break_serr", {31'd0, bus.seq_err}, 32'd1);
    capture(8'h06);
    chk("resync_serr", {31'd0, bus.seq_err}, 32'd1);

    // Long ack: data changes while held high, only the rising-edge value is captured.
    bus.out_ready = 1'b0;
    bus.in_data   = 8'h07;
    bus.in_ack    = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      bus.in_data = 8'(8'h20 + i);
      tick();
    end
    bus.in_ack = 1'b0;
    tick();
    chk("long_count", {29'd0, bus.count},    32'd1);
    chk("long_data",  {24'd0, bus.out_data}, 32'h07);
    chk("long_words", {16'd0, bus.words},    32'd260);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
